// File: rtl/sdpram_be_pipe.sv
// sdpram_be_pipe: simple dual-port RAM, byte-lane writes on port A, registered reads on port B, self-clears after rst.
// Latency: READ_LATENCY (1 or 2) cycles from renb to doutb_valid; clear sequence takes MEM_DEPTH cycles after rst.
// Backpressure: none; wena/renb are dropped while busy. Define SDPRAM_BYPASS_EN for write-first same-address reads.
module sdpram_be_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int BYTE_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wena,
   input  logic [ADDR_WIDTH-1:0]            addra,
   input  logic [DATA_WIDTH-1:0]            dina,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] bea,
   input  logic                             renb,
   input  logic [ADDR_WIDTH-1:0]            addrb,
   output logic [DATA_WIDTH-1:0]            doutb,
   output logic                             doutb_valid,
   output logic                             busy
);

   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

   generate
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
         $error("sdpram_be_pipe: READ_LATENCY must be 1 or 2");
      end
      if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
         $error("sdpram_be_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
   endgenerate

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   clr_ptr_q;
   logic [ADDR_WIDTH-1:0]   clr_ptr_d;
   logic                    clr_last;

   logic                    wr_en;
   logic                    rd_en;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdat;
   logic [NUM_BYTES-1:0]    mem_wbe;

   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0]   rd_old;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic                    s1_vld;
   logic [DATA_WIDTH-1:0]   s1_dat;

   assign clr_last = (clr_ptr_q == {ADDR_WIDTH{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // The clear walk owns the write port in CLEAR; user traffic only reaches the array in READY.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      busy      = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = addra;
      mem_wdat  = dina;
      mem_wbe   = bea;
      case (state_q)
         CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdat  = '0;
            mem_wbe   = '1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_last) begin
               state_d = READY;
            end
         end
         READY: begin
            wr_en  = wena & ~rst;
            rd_en  = renb & ~rst;
            mem_we = wr_en;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_wbe[i]) begin
               mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   assign rd_old = mem[addrb];

`ifdef SDPRAM_BYPASS_EN
   // Write-first: enabled lanes of a colliding write are forwarded straight from dina.
   always_comb begin
      rd_word = rd_old;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (wr_en && (addra == addrb) && bea[i]) begin
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end
`else
   assign rd_word = rd_old;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else begin
         s1_vld <= rd_en;
         if (rd_en) begin
            s1_dat <= rd_word;
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  s2_vld;
         logic [DATA_WIDTH-1:0] s2_dat;

         always_ff @(posedge clk) begin
            if (rst) begin
               s2_vld <= 1'b0;
               s2_dat <= '0;
            end else begin
               s2_vld <= s1_vld;
               if (s1_vld) begin
                  s2_dat <= s1_dat;
               end
            end
         end

         assign doutb       = s2_dat;
         assign doutb_valid = s2_vld;
      end else begin : g_lat1
         assign doutb       = s1_dat;
         assign doutb_valid = s1_vld;
      end
   endgenerate

endmodule

// File: tb/tb_sdpram_be_pipe.sv
// Bench for sdpram_be_pipe: drives one stimulus stream into a READ_LATENCY=1 and a READ_LATENCY=2 instance,
// predicting reads from a plain array model and checking them in a negedge monitor through per-instance queues.
module tb_sdpram_be_pipe;

   localparam int DEPTH = 256;

   typedef struct {
      logic [31:0] dat;
      int          due;
   } exp_t;

   logic        clk_tb = 1'b0;
   always #5 clk_tb = ~clk_tb;

   logic        rst   = 1'b1;
   logic        wena  = 1'b0;
   logic        renb  = 1'b0;
   logic [7:0]  addra = '0;
   logic [7:0]  addrb = '0;
   logic [31:0] dina  = '0;
   logic [3:0]  bea   = '0;

   logic [31:0] doutb_l1;
   logic [31:0] doutb_l2;
   logic        vld_l1;
   logic        vld_l2;
   logic        busy_l1;
   logic        busy_l2;

   sdpram_be_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_dut_l1 (
      .clk(clk_tb), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .bea(bea),
      .renb(renb), .addrb(addrb), .doutb(doutb_l1), .doutb_valid(vld_l1), .busy(busy_l1)
   );

   sdpram_be_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(2)) u_dut_l2 (
      .clk(clk_tb), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .bea(bea),
      .renb(renb), .addrb(addrb), .doutb(doutb_l2), .doutb_valid(vld_l2), .busy(busy_l2)
   );

   int          cyc = 0;
   always @(posedge clk_tb) cyc <= cyc + 1;

   logic [31:0] ref_mem [DEPTH];
   exp_t        exp_q [2][$];
   logic [31:0] hold [2];
   int          clear_left = 0;
   int          rst_edge   = -1;
   logic        busy_exp   = 1'b0;
   int          busy_run   = 0;
   int          n_tests    = 0;
   int          n_fail     = 0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~mask) | (nw & mask);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_port(input int p, input logic v, input logic [31:0] d);
      exp_t  e;
      string tag;
      tag = $sformatf("L%0d", p + 1);
      if (cyc == rst_edge) begin
         chk({tag, " reset_valid"}, {31'b0, v}, 32'd0);
         chk({tag, " reset_dout"}, d, 32'd0);
         hold[p] = '0;
      end else if (v === 1'b1) begin
         if (exp_q[p].size() == 0) begin
            chk({tag, " unexpected_valid"}, {31'b0, v}, 32'd0);
         end else begin
            e = exp_q[p].pop_front();
            chk({tag, " read_cycle"}, 32'(cyc), 32'(e.due));
            chk({tag, " read_data"}, d, e.dat);
            hold[p] = e.dat;
         end
      end else begin
         if (exp_q[p].size() > 0 && exp_q[p][0].due <= cyc) begin
            e = exp_q[p].pop_front();
            chk({tag, " missing_valid"}, {31'b0, v}, 32'd1);
         end
         chk({tag, " hold_dout"}, d, hold[p]);
      end
   endtask

   always @(negedge clk_tb) begin
      if (cyc >= 1) begin
         mon_port(0, vld_l1, doutb_l1);
         mon_port(1, vld_l2, doutb_l2);
         chk("busy_l1", {31'b0, busy_l1}, {31'b0, busy_exp});
         chk("busy_l2", {31'b0, busy_l2}, {31'b0, busy_exp});
         if (cyc == rst_edge) begin
            busy_run = 1;
         end else if (busy_l1 === 1'b1) begin
            busy_run++;
         end else if (busy_run > 0) begin
            chk("busy_length", 32'(busy_run), 32'(DEPTH));
            busy_run = 0;
         end
      end
   end

   // One clock of stimulus; the model decides at issue time what the upcoming edge does.
   task automatic step(input logic r, input logic we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [7:0] ra);
      logic [31:0] rd_val;
      busy_exp = (clear_left > 0);
      rst   = r;
      wena  = we;
      addra = wa;
      dina  = wd;
      bea   = be;
      renb  = re;
      addrb = ra;
      if (r) begin
         for (int p = 0; p < 2; p++) begin
            while (exp_q[p].size() > 0 && exp_q[p][$].due > cyc) begin
               void'(exp_q[p].pop_back());
            end
         end
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         clear_left = DEPTH;
         rst_edge   = cyc + 1;
      end else if (clear_left > 0) begin
         clear_left--;
      end else begin
         if (re) begin
            rd_val = ref_mem[ra];
`ifdef SDPRAM_BYPASS_EN
            if (we && wa == ra) rd_val = merge(rd_val, wd, be);
`endif
            exp_q[0].push_back('{rd_val, cyc + 1});
            exp_q[1].push_back('{rd_val, cyc + 2});
         end
         if (we) ref_mem[wa] = merge(ref_mem[wa], wd, be);
      end
      @(posedge clk_tb);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      step(1'b0, 1'b1, a, d, be, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, a);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] wa;

      // Power-up clear, then the array must read back as zero at both ends and the middle.
      step(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
      repeat (DEPTH) idle();
      rd(8'h00);
      rd(8'h7F);
      rd(8'hFF);

      // Byte-lane merge, and a write with no lanes enabled.
      wr(8'h10, 32'hDEADBEEF, 4'hF);
      wr(8'h10, 32'h11223344, 4'b0101);
      rd(8'h10);
      wr(8'h40, 32'hFFFFFFFF, 4'h0);
      rd(8'h40);

      // Back-to-back reads must stream without bubbles.
      for (int i = 1; i <= 4; i++) wr(8'(i), 32'(i), 4'hF);
      for (int i = 1; i <= 4; i++) rd(8'(i));
      repeat (3) idle();

      // Same-address and different-address collisions.
      wr(8'h20, 32'hAAAAAAAA, 4'hF);
      step(1'b0, 1'b1, 8'h20, 32'h55555555, 4'b0011, 1'b1, 8'h20);
      rd(8'h20);
      wr(8'h22, 32'h0BADF00D, 4'hF);
      step(1'b0, 1'b1, 8'h21, 32'h12345678, 4'hF, 1'b1, 8'h22);
      rd(8'h21);

      // Reads in flight are dropped by reset; traffic during clear is ignored; reset mid-clear restarts it.
      rd(8'h10);
      rd(8'h20);
      step(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 8'(8'h30 + i[3:0]), $urandom, 4'hF, 1'b1, 8'(i));
      step(1'b1, 1'b1, 8'h30, 32'hCAFEBABE, 4'hF, 1'b1, 8'h30);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(8'h30 + i[3:0]), $urandom, 4'hF, 1'b1, 8'h30);
      for (int i = 0; i < 4; i++) rd(8'(8'h30 + i));
      rd(8'h10);

      // Random mix, biased towards a small address window so collisions are frequent.
      for (int i = 0; i < 10000; i++) begin
         wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         step(1'b0, 1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), ra);
      end

      repeat (4) idle();
      chk("drain_l1", 32'(exp_q[0].size()), 32'd0);
      chk("drain_l2", 32'(exp_q[1].size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
